// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter that shares one single-port memory between
// three requesters (0 = instruction fetch, 1 = load/store, 2 = external/debug).
// Each access is sequenced as IDLE -> ISSUE -> (WAIT -> RESP for reads) -> IDLE.
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_if_*                    fetch read request and address
//   i_ls_*                    load/store request, we, address, write data
//   i_ex_*                    external request, we, address, write data
//   o_gnt                     one-hot grant pulse {ex, ls, if} in the ISSUE cycle
//   o_rvalid                  one-hot read-data-valid pulse {ex, ls, if}
//   o_rdata                   registered read data shared by all requesters
//   o_busy                    high whenever the FSM is not idle
//   o_mem_*                   memory strobe, write enable, address and write data
//   i_mem_rdata               memory read data, valid MEM_LAT cycles after the strobe
module mem_port_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    input  logic              i_ls_req,
    input  logic              i_ls_we,
    input  logic [ADDR_W-1:0] i_ls_addr,
    input  logic [DATA_W-1:0] i_ls_wdata,
    input  logic              i_ex_req,
    input  logic              i_ex_we,
    input  logic [ADDR_W-1:0] i_ex_addr,
    input  logic [DATA_W-1:0] i_ex_wdata,
    output logic [2:0]        o_gnt,
    output logic [2:0]        o_rvalid,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_busy,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            r_state, w_next;
    logic [1:0]        r_last, r_id, w_c1, w_c2, w_win;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata;
    logic [3:0]        r_cnt;
    logic [2:0]        w_req;

    assign w_req       = {i_ex_req, i_ls_req, i_if_req};
    assign o_busy      = r_state != IDLE;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_rdata     = r_rdata;

    // Search order last+1, last+2, last (mod 3); the last winner has lowest priority.
    always_comb begin
        w_c1  = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
        w_c2  = (w_c1 == 2'd2) ? 2'd0 : w_c1 + 2'd1;
        w_win = w_req[w_c1] ? w_c1 : w_req[w_c2] ? w_c2 : r_last;
    end

    always_comb begin
        w_next   = r_state;
        o_gnt    = 3'b000;
        o_rvalid = 3'b000;
        o_mem_en = 1'b0;
        o_mem_we = 1'b0;
        case (r_state)
            IDLE:  w_next = (|w_req) ? ISSUE : IDLE;
            ISSUE: begin
                o_mem_en = 1'b1;
                o_mem_we = r_we;
                o_gnt    = 3'b001 << r_id;
                w_next   = r_we ? IDLE : WAIT;
            end
            WAIT:  w_next = (r_cnt == 4'd0) ? RESP : WAIT;
            RESP: begin
                o_rvalid = 3'b001 << r_id;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_last  <= 2'd2;
            r_id    <= 2'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && |w_req) begin
                r_id   <= w_win;
                r_last <= w_win;
                r_we   <= (w_win == 2'd2) ? i_ex_we : (w_win == 2'd1) ? i_ls_we : 1'b0;
                r_addr <= (w_win == 2'd2) ? i_ex_addr : (w_win == 2'd1) ? i_ls_addr : i_if_addr;
                // Fetch never writes, so the write-data bus keeps its previous value.
                if (w_win != 2'd0)
                    r_wdata <= (w_win == 2'd2) ? i_ex_wdata : i_ls_wdata;
            end
            if (r_state == ISSUE)
                r_cnt <= 4'(MEM_LAT - 1);
            if (r_state == WAIT) begin
                r_cnt <= r_cnt - 4'd1;
                if (r_cnt == 4'd0)
                    r_rdata <= i_mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with a read-data scoreboard
module tb_mem_port_arbiter;
  typedef struct packed {logic [2:0] oh; logic [7:0] d;} exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  logic if_req, ls_req, ls_we, ex_req, ex_we;
  logic [7:0] if_addr, ls_addr, ls_wdata, ex_addr, ex_wdata;
  logic [2:0] gnt, rvalid;
  logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic busy, mem_en, mem_we;
  logic if_req1;
  logic [7:0] if_addr1;
  logic [2:0] gnt1, rvalid1;
  logic [7:0] rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic busy1, mem_en1, mem_we1;
  int n_tests = 0, n_fail = 0, cyc = 0;
  exp_t q0[$], q1[$];
  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(2)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
    .i_ex_req(ex_req), .i_ex_we(ex_we), .i_ex_addr(ex_addr), .i_ex_wdata(ex_wdata),
    .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata), .o_busy(busy),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );
  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1)) dut1 (
    .i_clk(clk), .i_reset(reset),
    .i_if_req(if_req1), .i_if_addr(if_addr1),
    .i_ls_req(1'b0), .i_ls_we(1'b0), .i_ls_addr(8'h00), .i_ls_wdata(8'h00),
    .i_ex_req(1'b0), .i_ex_we(1'b0), .i_ex_addr(8'h00), .i_ex_wdata(8'h00),
    .o_gnt(gnt1), .o_rvalid(rvalid1), .o_rdata(rdata1), .o_busy(busy1),
    .o_mem_en(mem_en1), .o_mem_we(mem_we1), .o_mem_addr(mem_addr1),
    .o_mem_wdata(mem_wdata1), .i_mem_rdata(mem_rdata1)
  );
  logic [7:0] mem [256];
  bit wr [256];
  logic [7:0] pipe0, pipe1, pipe_l1;
  assign mem_rdata = pipe1;
  assign mem_rdata1 = pipe_l1;
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr[mem_addr] <= 1'b1;
    end
    pipe0 <= (mem_en && !mem_we) ? (wr[mem_addr] ? mem[mem_addr] : mem_addr ^ 8'hB5) : 8'hEE;
    pipe1 <= pipe0;
    pipe_l1 <= (mem_en1 && !mem_we1) ? (mem_addr1 ^ 8'h7E) : (8'hEE ^ mem_wdata1 ^ mem_wdata1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_cycle();
    exp_t e;
    chk("excl0", $onehot0(gnt) && $onehot0(rvalid) && !(|gnt && |rvalid), 1'b1);
    chk("excl1", $onehot0(gnt1) && $onehot0(rvalid1) && !(|gnt1 && |rvalid1), 1'b1);
    if (rvalid != 3'b000) begin
      if (q0.size() == 0) chk("rv_unexp0", rvalid, 3'b000);
      else begin
        e = q0.pop_front();
        chk("sb_rvalid0", rvalid, e.oh);
        chk("sb_rdata0", rdata, e.d);
      end
    end
    if (rvalid1 != 3'b000) begin
      if (q1.size() == 0) chk("rv_unexp1", rvalid1, 3'b000);
      else begin
        e = q1.pop_front();
        chk("sb_rvalid1", rvalid1, e.oh);
        chk("sb_rdata1", rdata1, e.d);
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask
  task automatic wait_gnt(output int at, output logic [2:0] g);
    at = -1;
    g = 3'b000;
    for (int i = 0; i < 20; i++) begin
      step();
      if (gnt != 3'b000) begin
        at = cyc;
        g = gnt;
        break;
      end
    end
  endtask
  initial begin
    int at, prev;
    logic [2:0] g;
    logic [2:0] seq [4];
    seq = '{3'b001, 3'b010, 3'b100, 3'b001};
    reset = 1'b1; if_req = 0; ls_req = 0; ls_we = 0; ex_req = 0; ex_we = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0; ex_addr = 0; ex_wdata = 0;
    if_req1 = 0; if_addr1 = 0;
    step(); step();
    reset = 1'b0;
    chk("rst_gnt", gnt, 3'b000);
    chk("rst_rvalid", rvalid, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_rdata", rdata, 8'h00);
    if_req = 1; if_addr = 8'h10; q0.push_back('{3'b001, 8'hA5});
    step();
    chk("rd_gnt", gnt, 3'b001);
    chk("rd_mem_en", mem_en, 1'b1);
    chk("rd_mem_we", mem_we, 1'b0);
    chk("rd_mem_addr", mem_addr, 8'h10);
    chk("rd_busy", busy, 1'b1);
    if_req = 0;
    step();
    chk("rd_e1_en", mem_en, 1'b0);
    step();
    chk("rd_e2_rv", rvalid, 3'b000);
    step();
    chk("rd_e3_rv", rvalid, 3'b001);
    chk("rd_e3_rdata", rdata, 8'hA5);
    step();
    chk("rd_e4_busy", busy, 1'b0);
    ls_req = 1; ls_we = 1; ls_addr = 8'h80; ls_wdata = 8'h3C;
    step();
    chk("wr_gnt", gnt, 3'b010);
    chk("wr_mem_en", mem_en, 1'b1);
    chk("wr_mem_we", mem_we, 1'b1);
    chk("wr_mem_addr", mem_addr, 8'h80);
    chk("wr_mem_wdata", mem_wdata, 8'h3C);
    ls_req = 0;
    step();
    chk("wr_busy", busy, 1'b0);
    chk("wr_en_off", mem_en, 1'b0);
    chk("wr_we_off", mem_we, 1'b0);
    chk("wr_addr_hold", mem_addr, 8'h80);
    chk("wr_mem", mem[8'h80], 8'h3C);
    step();
    chk("wr_no_rv", rvalid, 3'b000);
    reset = 1; step(); reset = 0;
    if_addr = 8'h01; ls_addr = 8'h02; ls_we = 0; ex_addr = 8'h03; ex_we = 0;
    if_req = 1; ls_req = 1; ex_req = 1;
    q0.push_back('{3'b001, 8'hB4}); q0.push_back('{3'b010, 8'hB7});
    q0.push_back('{3'b100, 8'hB6}); q0.push_back('{3'b001, 8'hB4});
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(at, g);
      chk("rr_gnt_timeout", at >= 0, 1'b1);
      chk("rr_gnt", g, seq[k]);
      if (k > 0) chk("rr_spacing", at - prev, 5);
      prev = at;
    end
    if_req = 0; ls_req = 0; ex_req = 0;
    for (int k = 0; k < 6; k++) step();
    chk("rr_drained", q0.size(), 0);
    ls_req = 1; ls_we = 1; ls_addr = 8'h44; ls_wdata = 8'h5A;
    step();
    chk("pend_ls_gnt", gnt, 3'b010);
    ls_req = 0; ex_req = 1; ex_we = 0; ex_addr = 8'h44; q0.push_back('{3'b100, 8'h5A});
    step();
    chk("pend_e1_gnt", gnt, 3'b000);
    step();
    chk("pend_e2_gnt", gnt, 3'b100);
    ex_req = 0;
    step(); step(); step();
    chk("pend_rv", rvalid, 3'b100);
    chk("pend_rdata", rdata, 8'h5A);
    step();
    ls_req = 1; ls_we = 0; ls_addr = 8'h02;
    step();
    chk("abort_gnt", gnt, 3'b010);
    ls_req = 0;
    step();
    chk("abort_wait_busy", busy, 1'b1);
    reset = 1;
    step();
    reset = 0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_rv", rvalid, 3'b000);
    chk("abort_rdata", rdata, 8'h00);
    for (int k = 0; k < 4; k++) step();
    chk("abort_idle", busy, 1'b0);
    if_req1 = 1; if_addr1 = 8'h00;
    q1.push_back('{3'b001, 8'h7E}); q1.push_back('{3'b001, 8'h7E});
    step();
    chk("l1_gnt", gnt1, 3'b001);
    step();
    chk("l1_e1_rv", rvalid1, 3'b000);
    step();
    chk("l1_rv", rvalid1, 3'b001);
    chk("l1_rdata", rdata1, 8'h7E);
    step();
    chk("l1_e3_gnt", gnt1, 3'b000);
    chk("l1_e3_busy", busy1, 1'b0);
    step();
    chk("l1_e4_gnt", gnt1, 3'b001);
    if_req1 = 0;
    for (int k = 0; k < 4; k++) step();
    chk("l1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single-port data/instruction memory between three requesters: 0 = instruction fetch, 1 = load/store datapath, 2 = external loader/debug port.
- Sits between the multicycle control unit/datapath and the memory macro.
- Grants one requester at a time using round-robin priority.
- Sequences each access through issue, latency wait and response.
- Returns read data to the requester with a one-cycle valid pulse.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 8, memory data width
MEM_LAT, 2, cycles from issue cycle to valid mem_rdata; legal range 1..15

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch read request (read-only requester)
if_addr  input  ADDR_W  fetch address
ls_req  input  1  load/store request
ls_we  input  1  1 = store, 0 = load
ls_addr  input  ADDR_W  load/store address
ls_wdata  input  DATA_W  store data
ex_req  input  1  external port request
ex_we  input  1  1 = write, 0 = read
ex_addr  input  ADDR_W  external address
ex_wdata  input  DATA_W  external write data
gnt  output  3  one-hot grant pulse {ex, ls, if}
rvalid  output  3  one-hot read-data-valid pulse {ex, ls, if}
rdata  output  DATA_W  registered read data, shared by all requesters
busy  output  1  high whenever state != IDLE
mem_en  output  1  memory access strobe, one cycle per access
mem_we  output  1  memory write enable, qualified by mem_en
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle

Behaviour:
- Reset (synchronous, highest priority):
  - state = IDLE; gnt, rvalid, mem_en, mem_we = 0; mem_addr, mem_wdata, rdata = 0; busy = 0.
  - RR pointer last = 2, so the first priority order is if > ls > ex.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Requests are sampled only in this state.
  - If any req is high: select the winner in rotating order last+1, last+2, last (mod 3).
  - Latch the winner id, we (forced 0 for if), addr and wdata; set last = winner; go to ISSUE.
  - If no req is high: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_en = 1 and gnt[winner] = 1.
  - mem_we, mem_addr and mem_wdata are driven from the latched values.
  - Write: next state IDLE. No rvalid is generated.
  - Read: load the latency counter with MEM_LAT-1; next state WAIT.
- WAIT:
  - Lasts exactly MEM_LAT cycles; the counter decrements each cycle.
  - In the cycle the counter is 0, capture mem_rdata into rdata and go to RESP.
- RESP (1 cycle): rvalid[winner] = 1, rdata holds the captured value; next state IDLE.
- Latency, with E = ISSUE cycle:
  - Request sampled in IDLE at cycle E-1.
  - Read response (rvalid) at cycle E+MEM_LAT+1.
  - Earliest next ISSUE: E+2 after a write, E+MEM_LAT+3 after a read.
- Requester handshake:
  - Hold req, we, addr and wdata stable until gnt. Deassert req in the gnt cycle unless a new access is wanted.
  - A req dropped before being sampled is simply not served.
  - Request inputs are ignored while busy = 1.
- Outputs outside their states:
  - mem_en = 0 and mem_we = 0 outside ISSUE.
  - mem_addr and mem_wdata hold their last values.
  - rdata holds until the next read capture.
- gnt and rvalid are one-hot or zero every cycle and never assert in the same cycle.
- Fairness: with all three requesters continuously requesting, grants go if, ls, ex, if, ...; no requester waits more than 2 foreign accesses.
- Reset mid-operation:
  - Aborts the access in any state; no rvalid is issued.
  - A write already strobed to memory stands.

Test Plan:
- Reset, then if_req=1, if_addr=0x10, mem returns 0xA5 (MEM_LAT=2) -> gnt=001 at cycle E, mem_en=1/mem_we=0/mem_addr=0x10 at E, rvalid=001 with rdata=0xA5 at E+3.
- ls_req=1, ls_we=1, ls_addr=0x80, ls_wdata=0x3C -> single mem_en cycle with mem_we=1, addr 0x80, data 0x3C; gnt=010; no rvalid; busy low at E+1.
- All three requesting reads continuously from reset -> gnt sequence 001, 010, 100, 001; each rvalid matches its grant; gnt spacing MEM_LAT+3 cycles.
- ex read pending while ls write is in ISSUE -> ex not granted until after the write; ex gnt at write E+2.
- Reset asserted during WAIT of an ls read -> next cycle state IDLE, busy=0, no rvalid pulse, rdata=0.
- MEM_LAT=1 build, if read of 0x00 returning 0x7E -> rvalid at E+2 with rdata=0x7E; a back-to-back request is granted at E+4.
